fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/fetch_pc_reg.sv | 38 +++
 rtl/fetch_stage.sv | 178 +++++++++++++++++
 tb/tb_fetch_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch FSM states and the default reset PC.
// Both fetch_pc_reg and fetch_stage import this package.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_REQ  = 3'd1,
        FS_WAIT = 3'd2,
        FS_HOLD = 3'd3,
        FS_KILL = 3'd4
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: redirect takes priority over the sequential +4 advance.
// Redirect targets are always word-aligned before they are loaded.
module fetch_pc_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = align_pc(redirect_pc_i);
        end else if (advance_i) begin
            pc_d = pc_plus4(pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request FSM, one-entry skid and IF/ID register.
// Optional FETCH_MISALIGN_CHK_EN adds fetch_misalign_o, a one-cycle flag for misaligned redirects.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        fetch_misalign_o
`endif
);

    // state | meaning
    // IDLE  | one cycle after reset, no request
    // REQ   | request at pc, waiting for grant
    // WAIT  | granted, waiting for rvalid
    // HOLD  | word parked in skid while decode is stalled
    // KILL  | outstanding response belongs to a squashed path, drop it

    fetch_state_e state_d, state_q;
    logic [31:0]  pc;
    logic         advance;
    logic [31:0]  pend_pc_d, pend_pc_q;
    logic         skid_valid_d, skid_valid_q;
    logic [31:0]  skid_instr_d, skid_instr_q;
    logic [31:0]  skid_pc_d, skid_pc_q;
    logic         ifid_valid_d, ifid_valid_q;
    logic [31:0]  ifid_instr_d, ifid_instr_q;
    logic [31:0]  ifid_pc_d, ifid_pc_q;
    logic [31:0]  ifid_pc4_d, ifid_pc4_q;

    assign advance = (state_q == FS_REQ) && imem_gnt_i;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk              (clk),
        .rst_n            (rst_n),
        .advance_i        (advance),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pc_o             (pc)
    );

    always_comb begin
        state_d      = state_q;
        pend_pc_d    = pend_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;

        // Decode consumes the IF/ID word whenever it is not stalled.
        if (!stall_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end

        unique case (state_q)
            FS_IDLE: state_d = FS_REQ;
            FS_REQ: begin
                if (imem_gnt_i) begin
                    pend_pc_d = pc;
                    state_d   = redirect_valid_i ? FS_KILL : FS_WAIT;
                end
            end
            FS_WAIT: begin
                // A response coinciding with the redirect is simply dropped here.
                if (redirect_valid_i) begin
                    state_d = imem_rvalid_i ? FS_REQ : FS_KILL;
                end else if (imem_rvalid_i) begin
                    if (!stall_i || !ifid_valid_q) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = imem_rdata_i;
                        ifid_pc_d    = pend_pc_q;
                        ifid_pc4_d   = pc_plus4(pend_pc_q);
                        state_d      = FS_REQ;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata_i;
                        skid_pc_d    = pend_pc_q;
                        state_d      = FS_HOLD;
                    end
                end
            end
            FS_HOLD: begin
                if (redirect_valid_i) begin
                    state_d = FS_REQ;
                end else if (!stall_i) begin
                    ifid_valid_d = 1'b1;
                    ifid_instr_d = skid_instr_q;
                    ifid_pc_d    = skid_pc_q;
                    ifid_pc4_d   = pc_plus4(skid_pc_q);
                    skid_valid_d = 1'b0;
                    state_d      = FS_REQ;
                end
            end
            FS_KILL: begin
                if (imem_rvalid_i) begin
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_IDLE;
        endcase

        if (redirect_valid_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FS_IDLE;
            pend_pc_q    <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'h0;
            ifid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pend_pc_q    <= pend_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_d, misalign_q;

    assign misalign_d = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_misalign_o = misalign_q;
`endif

    assign imem_req_o   = (state_q == FS_REQ);
    assign imem_addr_o  = pc;
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a memory returning mem[a] = a ^ 32'hA5A5_0000.
// Memory latency is adjustable (1 = zero-wait) so redirects can land in WAIT before rvalid.
module tb_fetch_stage;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign_o;
`endif

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int cnt   = 0;
    logic [31:0] paddr = 32'h0;

    fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .ifid_valid_o     (ifid_valid_o),
        .ifid_instr_o     (ifid_instr_o),
        .ifid_pc_o        (ifid_pc_o),
        .ifid_pc4_o       (ifid_pc4_o)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .fetch_misalign_o (fetch_misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_gnt_i = imem_req_o;

    // Memory model: not reset, so a response can arrive late across a DUT reset.
    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
    end
    always @(posedge clk) begin
        imem_rvalid_i <= 1'b0;
        if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                imem_rvalid_i <= 1'b1;
                imem_rdata_i  <= paddr ^ K;
            end
        end
        if (imem_req_o && imem_gnt_i) begin
            if (lat <= 1) begin
                imem_rvalid_i <= 1'b1;
                imem_rdata_i  <= imem_addr_o ^ K;
            end else begin
                paddr <= imem_addr_o;
                cnt   <= lat - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, ifid_valid_o}, 32'd1);
        chk({tag, "_instr"}, ifid_instr_o, pc ^ K);
        chk({tag, "_pc"},    ifid_pc_o,    pc);
        chk({tag, "_pc4"},   ifid_pc4_o,   pc + 32'd4);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {31'd0, ifid_valid_o}, 32'd0);
        chk({tag, "_instr"}, ifid_instr_o, NOP);
    endtask

    task automatic chk_reset(input string tag);
        chk_empty(tag);
        chk({tag, "_pc"},   ifid_pc_o,   32'h0);
        chk({tag, "_pc4"},  ifid_pc4_o,  32'h0);
        chk({tag, "_req"},  {31'd0, imem_req_o}, 32'd0);
        chk({tag, "_addr"}, imem_addr_o, 32'h0);
    endtask

    initial begin
        rst_n            = 1'b0;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;

        // Reset and first fetches
        tick(); tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();
        chk_empty("c1");
        chk("c1_req",  {31'd0, imem_req_o}, 32'd1);
        chk("c1_addr", imem_addr_o, 32'h0);
        tick();
        chk_empty("c2");
        chk("c2_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        chk_ifid("first_pc0", 32'h0);
        tick();
        chk_empty("bubble");
        tick();
        chk_ifid("pc4", 32'h4);
        tick(); tick();
        chk_ifid("pc8", 32'h8);

        // Stall for 5 cycles while the next word returns
        stall_i = 1'b1;
        tick();
        chk_ifid("stall_e8", 32'h8);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_ifid("stall_frozen", 32'h8);
            chk("hold_noreq", {31'd0, imem_req_o}, 32'd0);
        end
        stall_i = 1'b0;
        tick();
        chk_ifid("skid_out", 32'hC);
        chk("post_hold_req",  {31'd0, imem_req_o}, 32'd1);
        chk("post_hold_addr", imem_addr_o, 32'h10);

        // Redirect while WAIT, response still in flight
        lat = 2;
        tick();
        chk("wait_req", {31'd0, imem_req_o}, 32'd0);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0100;
        tick();
        redirect_valid_i = 1'b0;
        chk_empty("kill");
        chk("kill_req",  {31'd0, imem_req_o}, 32'd0);
        chk("kill_addr", imem_addr_o, 32'h100);
        tick();
        chk_empty("stale_dropped");
        chk("redir_req",  {31'd0, imem_req_o}, 32'd1);
        chk("redir_addr", imem_addr_o, 32'h100);
        lat = 1;
        tick(); tick();
        chk_ifid("redir_target", 32'h100);

        // Redirect and stall together
        stall_i          = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0200;
        tick();
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        chk_empty("rs_inval");
        chk("rs_addr", imem_addr_o, 32'h200);
        tick();
        chk_empty("rs_drop");
        chk("rs_req", {31'd0, imem_req_o}, 32'd1);
        tick(); tick();
        chk_ifid("rs_target", 32'h200);

        // PC wrap at the top of the address space
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFC;
        tick();
        redirect_valid_i = 1'b0;
        tick();
        chk("wrap_addr_top", imem_addr_o, 32'hFFFF_FFFC);
        chk("wrap_req", {31'd0, imem_req_o}, 32'd1);
        tick();
        chk("wrap_addr_zero", imem_addr_o, 32'h0);
        tick();
        chk("wrap_instr", ifid_instr_o, 32'h5A5A_FFFC);
        chk("wrap_pc",    ifid_pc_o,    32'hFFFF_FFFC);
        chk("wrap_pc4",   ifid_pc4_o,   32'h0);
        chk("wrap_next",  imem_addr_o,  32'h0);

        // Reset with a request outstanding; its late response must be ignored
        lat = 2;
        tick();
        chk("mid_wait", {31'd0, imem_req_o}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk_reset("mid_rst");
        rst_n = 1'b1;
        lat   = 1;
        tick();
        chk_empty("late_ignored");
        chk("rel_req",  {31'd0, imem_req_o}, 32'd1);
        chk("rel_addr", imem_addr_o, 32'h0);
        tick();
        chk_empty("rel_wait");
        tick();
        chk_ifid("rel_first", 32'h0);

        // Misaligned redirect
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_idle", {31'd0, fetch_misalign_o}, 32'd0);
`endif
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0102;
        tick();
        redirect_valid_i = 1'b0;
        chk("mis_addr", imem_addr_o, 32'h100);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_pulse", {31'd0, fetch_misalign_o}, 32'd1);
`endif
        tick();
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_clear", {31'd0, fetch_misalign_o}, 32'd0);
`endif
        chk("mis_req", {31'd0, imem_req_o}, 32'd1);
        chk("mis_addr2", imem_addr_o, 32'h100);
        tick(); tick();
        chk_ifid("mis_target", 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
